// File: rtl/tx_packet_scheduler_if.sv
// tx_packet_scheduler_if
// Groups the requester handshakes and the encoder-facing packet bus of the
// TX packet scheduler.
//   slave  : scheduler side (takes requests and tx_done, drives grants and
//            the packet type/size towards the encoder)
//   master : requester/encoder side (the mirror image of slave)
// Signals:
//   hs_req/hs_nak/hs_grant      handshake (ACK/NAK) requester
//   data_req/data_size/data_grant   DATA packet requester
//   tx_packet/tx_packet_data_size   packet type and payload size to encoder
//   tx_done                     end-of-packet pulse from encoder
//   size_err/tx_abort/busy      status pulses and busy level
interface tx_packet_scheduler_if;
  logic       hs_req;
  logic       hs_nak;
  logic       hs_grant;
  logic       data_req;
  logic [6:0] data_size;
  logic       data_grant;
  logic [1:0] tx_packet;
  logic [6:0] tx_packet_data_size;
  logic       tx_done;
  logic       size_err;
  logic       tx_abort;
  logic       busy;

  modport slave (
    input  hs_req, hs_nak, data_req, data_size, tx_done,
    output hs_grant, data_grant, tx_packet, tx_packet_data_size,
           size_err, tx_abort, busy
  );

  modport master (
    output hs_req, hs_nak, data_req, data_size, tx_done,
    input  hs_grant, data_grant, tx_packet, tx_packet_data_size,
           size_err, tx_abort, busy
  );
endinterface

// File: rtl/tx_packet_scheduler.sv
// tx_packet_scheduler
// Shares one USB TX packet encoder between the handshake responder (ACK/NAK)
// and the data path (DATA packets). A granted packet type and size are held
// towards the encoder until tx_done, then an idle gap of GAP_CYCLES clocks
// is enforced before the next grant. Handshakes win over data requests.
// Ports:
//   clk  system clock
//   rst  synchronous reset, active-high
//   bus  tx_packet_scheduler_if.slave (requests, grants, encoder bus, status)
// Parameters:
//   GAP_CYCLES   idle clocks after tx_done before the next grant (0 = none)
//   MAX_SIZE     largest DATA payload; larger requests are clamped + size_err
//   WDOG_CYCLES  ACTIVE-state watchdog limit
// Optional feature:
//   TX_SCHED_WATCHDOG_EN  when defined, a 13-bit watchdog aborts a packet that
//   never sees tx_done; otherwise ACTIVE waits forever and tx_abort is 0.
module tx_packet_scheduler #(
  parameter int GAP_CYCLES  = 16,
  parameter int MAX_SIZE    = 64,
  parameter int WDOG_CYCLES = 4096
) (
  input logic                  clk,
  input logic                  rst,
  tx_packet_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    GAP
  } state_t;

  // Gap counter loads GAP_CYCLES-1, so it needs clog2(GAP_CYCLES) bits.
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [6:0] MAX_SIZE_V = 7'(MAX_SIZE);

  // Reject parameter values the fixed-width logic cannot represent.
  if (MAX_SIZE < 0 || MAX_SIZE > 127) begin : g_bad_max_size
    $error("tx_packet_scheduler: MAX_SIZE must be within 0..127");
  end
  if (GAP_CYCLES < 0) begin : g_bad_gap
    $error("tx_packet_scheduler: GAP_CYCLES must not be negative");
  end
  if (WDOG_CYCLES < 1 || WDOG_CYCLES > 8191) begin : g_bad_wdog
    $error("tx_packet_scheduler: WDOG_CYCLES must be within 1..8191");
  end

  state_t           state, state_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_nxt;
  logic [1:0]       pkt_q, pkt_nxt;
  logic [6:0]       size_q, size_nxt;
  logic             hs_grant_q, hs_grant_nxt;
  logic             data_grant_q, data_grant_nxt;
  logic             size_err_q, size_err_nxt;
  logic             busy_q;

`ifdef TX_SCHED_WATCHDOG_EN
  localparam logic [12:0] WDOG_LAST = 13'(WDOG_CYCLES - 1);
  logic [12:0] wdog_cnt, wdog_nxt;
  logic        abort_q, abort_nxt;
`endif

  // Next-state and next-output logic. Pulse outputs default to 0 so they
  // last exactly one cycle; packet type/size default to holding.
  always_comb begin
    state_nxt      = state;
    gap_nxt        = gap_cnt;
    pkt_nxt        = pkt_q;
    size_nxt       = size_q;
    hs_grant_nxt   = 1'b0;
    data_grant_nxt = 1'b0;
    size_err_nxt   = 1'b0;
`ifdef TX_SCHED_WATCHDOG_EN
    wdog_nxt       = wdog_cnt;
    abort_nxt      = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (bus.hs_req) begin
          state_nxt    = ACTIVE;
          pkt_nxt      = bus.hs_nak ? 2'b11 : 2'b10;
          size_nxt     = 7'd0;
          hs_grant_nxt = 1'b1;
`ifdef TX_SCHED_WATCHDOG_EN
          wdog_nxt     = 13'd0;
`endif
        end else if (bus.data_req) begin
          state_nxt      = ACTIVE;
          pkt_nxt        = 2'b01;
          data_grant_nxt = 1'b1;
          if (bus.data_size > MAX_SIZE_V) begin
            size_nxt     = MAX_SIZE_V;
            size_err_nxt = 1'b1;
          end else begin
            size_nxt = bus.data_size;
          end
`ifdef TX_SCHED_WATCHDOG_EN
          wdog_nxt = 13'd0;
`endif
        end
      end
      ACTIVE: begin
        // Completion and watchdog expiry share the same exit path; a
        // tx_done arriving together with expiry counts as a normal finish.
        if (bus.tx_done
`ifdef TX_SCHED_WATCHDOG_EN
            || (wdog_cnt == WDOG_LAST)
`endif
           ) begin
          pkt_nxt  = 2'b00;
          size_nxt = 7'd0;
          if (GAP_CYCLES == 0) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = GAP;
            gap_nxt   = GAP_LOAD;
          end
`ifdef TX_SCHED_WATCHDOG_EN
          abort_nxt = !bus.tx_done;
`endif
        end
`ifdef TX_SCHED_WATCHDOG_EN
        else begin
          wdog_nxt = wdog_cnt + 13'd1;
        end
`endif
      end
      GAP: begin
        if (gap_cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          gap_nxt = gap_cnt - 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        pkt_nxt   = 2'b00;
        size_nxt  = 7'd0;
      end
    endcase
  end

  // State and output registers. busy is registered from the next state so
  // it tracks state != IDLE without a combinational output path.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      gap_cnt      <= '0;
      pkt_q        <= 2'b00;
      size_q       <= 7'd0;
      hs_grant_q   <= 1'b0;
      data_grant_q <= 1'b0;
      size_err_q   <= 1'b0;
      busy_q       <= 1'b0;
`ifdef TX_SCHED_WATCHDOG_EN
      wdog_cnt     <= 13'd0;
      abort_q      <= 1'b0;
`endif
    end else begin
      state        <= state_nxt;
      gap_cnt      <= gap_nxt;
      pkt_q        <= pkt_nxt;
      size_q       <= size_nxt;
      hs_grant_q   <= hs_grant_nxt;
      data_grant_q <= data_grant_nxt;
      size_err_q   <= size_err_nxt;
      busy_q       <= (state_nxt != IDLE);
`ifdef TX_SCHED_WATCHDOG_EN
      wdog_cnt     <= wdog_nxt;
      abort_q      <= abort_nxt;
`endif
    end
  end

  assign bus.tx_packet           = pkt_q;
  assign bus.tx_packet_data_size = size_q;
  assign bus.hs_grant            = hs_grant_q;
  assign bus.data_grant          = data_grant_q;
  assign bus.size_err            = size_err_q;
  assign bus.busy                = busy_q;
`ifdef TX_SCHED_WATCHDOG_EN
  assign bus.tx_abort            = abort_q;
`else
  assign bus.tx_abort            = 1'b0;
`endif

endmodule
